// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake, ALU operand/result bus, flags and debug read port.
// Ports (signals):
//   instr_valid/instr_ready/instr  instruction handshake and 16-bit instruction word
//   alu_a/alu_b/alu_o              operands and opcode presented to the external ALU
//   alu_r/alu_c/alu_z              ALU result, carry and zero returned to the sequencer
//   done/flag_c/flag_z             retire pulse and registered flags
//   dbg_sel/dbg_data               register-file debug read
// master = environment side, slave = sequencer side.
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_o;
    logic [15:0] alu_r;
    logic        alu_c;
    logic        alu_z;
    logic        done;
    logic        flag_c;
    logic        flag_z;
    logic [2:0]  dbg_sel;
    logic [7:0]  dbg_data;
    modport master (
        output instr_valid, instr, alu_r, alu_c, alu_z, dbg_sel,
        input  instr_ready, alu_a, alu_b, alu_o, done, flag_c, flag_z, dbg_data
    );
    modport slave (
        input  instr_valid, instr, alu_r, alu_c, alu_z, dbg_sel,
        output instr_ready, alu_a, alu_b, alu_o, done, flag_c, flag_z, dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences load-immediate and ALU instructions over an 8x8 register file.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_sequencer_if.slave: instruction handshake, ALU bus, flags, done, debug read
module alu_sequencer #(
    parameter logic [7:0] RF_INIT   = 8'h00,
    parameter bit         MUL_HI_WB = 1'b1
) (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WB, WB_HI} state_t;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        mode_q, mode_d;
    logic [2:0]  rd_q, rd_d;
    logic [7:0]  imm_q, imm_d;
    logic [7:0]  rf_q [8];
    logic [7:0]  rf_d [8];
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_o_q, alu_o_d;
    logic [15:0] res_q, res_d;
    logic        res_c_q, res_c_d;
    logic        res_z_q, res_z_d;
    logic        flag_c_q, flag_c_d;
    logic        flag_z_q, flag_z_d;
    logic        done_q, done_d;
    logic        accept;
    logic        hi_wb;
    logic [2:0]  rd_hi;
    assign bus.instr_ready = (state_q == IDLE) && !rst;
    assign accept          = bus.instr_valid && bus.instr_ready;
    // Mul needs an extra write cycle for the high byte only when enabled.
    assign hi_wb           = !mode_q && (op_q == OP_MUL) && MUL_HI_WB;
    // 3-bit add wraps rd=7 onto R0.
    assign rd_hi           = rd_q + 3'd1;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_o       = alu_o_q;
    assign bus.done        = done_q;
    assign bus.flag_c      = flag_c_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.dbg_data    = rf_q[bus.dbg_sel];
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mode_d   = mode_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        rf_d     = rf_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_o_d  = alu_o_q;
        res_d    = res_q;
        res_c_d  = res_c_q;
        res_z_d  = res_z_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = bus.instr[15:13];
                mode_d  = bus.instr[12];
                rd_d    = bus.instr[11:9];
                imm_d   = bus.instr[7:0];
                state_d = bus.instr[12] ? WB : EXEC;
                // Operands are registered on accept so they are stable for all of EXEC.
                if (!bus.instr[12]) begin
                    alu_a_d = rf_q[bus.instr[8:6]];
                    alu_b_d = rf_q[bus.instr[5:3]];
                    alu_o_d = bus.instr[15:13];
                end
            end
            EXEC: begin
                res_d   = bus.alu_r;
                res_c_d = bus.alu_c;
                res_z_d = bus.alu_z;
                state_d = WB;
            end
            WB: begin
                rf_d[rd_q] = mode_q ? imm_q : res_q[7:0];
                flag_z_d   = mode_q ? flag_z_q : res_z_q;
                flag_c_d   = (!mode_q && (op_q == OP_ADD || op_q == OP_SUB)) ? res_c_q : flag_c_q;
                state_d    = hi_wb ? WB_HI : IDLE;
                done_d     = !hi_wb;
            end
            WB_HI: begin
                rf_d[rd_hi] = res_q[15:8];
                state_d     = IDLE;
                done_d      = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mode_q   <= 1'b0;
            rd_q     <= '0;
            imm_q    <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= RF_INIT;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_o_q  <= '0;
            res_q    <= '0;
            res_c_q  <= 1'b0;
            res_z_q  <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            rf_q     <= rf_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_o_q  <= alu_o_d;
            res_q    <= res_d;
            res_c_q  <= res_c_d;
            res_z_q  <= res_z_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer (default and no-Mul-high-writeback builds).
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    alu_sequencer_if bus0 ();
    alu_sequencer_if bus1 ();
    alu_sequencer u0 (.clk(clk), .rst(rst), .bus(bus0));
    alu_sequencer #(.RF_INIT(8'h5A), .MUL_HI_WB(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    always #5 clk = ~clk;
    assign bus1.instr_valid = bus0.instr_valid;
    assign bus1.instr       = bus0.instr;
    assign bus1.dbg_sel     = bus0.dbg_sel;
    function automatic logic [17:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        case (o)
            3'd0: {c, r[7:0]} = {1'b0, a} + {1'b0, b};
            3'd1: begin r[7:0] = a - b; c = a < b; end
            3'd2: r = a * b;
            3'd3: r[7:0] = a & b;
            3'd4: r[7:0] = a | b;
            3'd5: r[7:0] = ~(a & b);
            3'd6: r[7:0] = ~(a | b);
            default: r[7:0] = a ^ b;
        endcase
        if (o != 3'd2) r[15:8] = 8'h00;
        return {c, r == 16'h0000, r};
    endfunction
    always_comb {bus0.alu_c, bus0.alu_z, bus0.alu_r} = alu_model(bus0.alu_a, bus0.alu_b, bus0.alu_o);
    always_comb {bus1.alu_c, bus1.alu_z, bus1.alu_r} = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_o);
    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic logic [15:0] li(input logic [2:0] rd, input logic [7:0] imm);
        return {3'b000, 1'b1, rd, 1'b0, imm};
    endfunction
    function automatic logic [15:0] op(input logic [2:0] o, input logic [2:0] rd, input logic [2:0] a, input logic [2:0] b);
        return {o, 1'b0, rd, a, b, 3'b000};
    endfunction
    task automatic run(input logic [15:0] ins, output int lat);
        lat = 0;
        @(negedge clk);
        bus0.instr       = ins;
        bus0.instr_valid = 1'b1;
        for (int i = 0; i < 10 && !bus0.instr_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 bus0.instr_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus0.done) begin
                lat = i;
                break;
            end
        end
    endtask
    task automatic peek(input logic [2:0] s);
        bus0.dbg_sel = s;
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat;
        int k;
        logic [15:0] q [3];
        bus0.instr_valid = 1'b0;
        bus0.instr       = '0;
        bus0.dbg_sel     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus0.instr_ready, 0);
        check("rst_done", bus0.done, 0);
        check("rst_flags", {bus0.flag_c, bus0.flag_z}, 0);
        check("rst_alu", {bus0.alu_a, bus0.alu_b, 5'd0, bus0.alu_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", bus0.instr_ready, 1);
        peek(3'd5);
        check("rf_init0", bus0.dbg_data, 8'h00);
        check("rf_init1", bus1.dbg_data, 8'h5A);
        run(li(3'd1, 8'h0F), lat);
        check("li_lat", lat, 2);
        peek(3'd1);
        check("li_r1", bus0.dbg_data, 8'h0F);
        check("li_flags", {bus0.flag_c, bus0.flag_z}, 0);
        run(li(3'd2, 8'hF1), lat);
        peek(3'd2);
        check("li_r2", bus0.dbg_data, 8'hF1);
        run(op(3'd0, 3'd3, 3'd1, 3'd2), lat);
        check("add_lat", lat, 3);
        peek(3'd3);
        check("add_r3", bus0.dbg_data, 8'h00);
        check("add_fz", bus0.flag_z, 1);
        check("add_fc", bus0.flag_c, 1);
        check("alu_hold", {bus0.alu_a, bus0.alu_b}, 16'h0FF1);
        run(op(3'd2, 3'd7, 3'd1, 3'd2), lat);
        check("mul_lat", lat, 4);
        peek(3'd7);
        check("mul_r7", bus0.dbg_data, 8'h1F);
        check("mul_r7_nohi", bus1.dbg_data, 8'h1F);
        peek(3'd0);
        check("mul_r0_wrap", bus0.dbg_data, 8'h0E);
        check("mul_r0_nohi", bus1.dbg_data, 8'h5A);
        check("mul_fc_hold", bus0.flag_c, 1);
        check("mul_fz", bus0.flag_z, 0);
        run(op(3'd1, 3'd4, 3'd1, 3'd2), lat);
        peek(3'd4);
        check("sub_r4", bus0.dbg_data, 8'h1E);
        check("sub_flags", {bus0.flag_c, bus0.flag_z}, 2'b10);
        run(op(3'd3, 3'd5, 3'd1, 3'd6), lat);
        peek(3'd5);
        check("and_r5", bus0.dbg_data, 8'h00);
        check("and_flags", {bus0.flag_c, bus0.flag_z}, 2'b11);
        run(op(3'd0, 3'd5, 3'd1, 3'd1), lat);
        peek(3'd5);
        check("add2_r5", bus0.dbg_data, 8'h1E);
        check("add2_flags", {bus0.flag_c, bus0.flag_z}, 2'b00);
        run(op(3'd5, 3'd6, 3'd1, 3'd2), lat);
        peek(3'd6);
        check("nand_r6", bus0.dbg_data, 8'hFE);
        check("nand_flags", {bus0.flag_c, bus0.flag_z}, 2'b00);
        run(op(3'd6, 3'd6, 3'd1, 3'd2), lat);
        peek(3'd6);
        check("nor_r6", bus0.dbg_data, 8'h00);
        check("nor_fz", bus0.flag_z, 1);
        q[0] = op(3'd0, 3'd3, 3'd1, 3'd1);
        q[1] = op(3'd0, 3'd3, 3'd3, 3'd1);
        q[2] = op(3'd0, 3'd3, 3'd3, 3'd3);
        k = 0;
        @(negedge clk);
        bus0.instr       = q[0];
        bus0.instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic was_ready;
            was_ready = bus0.instr_ready;
            check($sformatf("b2b_ready%0d", c), was_ready, (c < 9) ? (c % 3 == 0) : 1);
            check($sformatf("b2b_done%0d", c), bus0.done, (c == 3 || c == 6 || c == 9));
            @(posedge clk);
            #1;
            if (was_ready && bus0.instr_valid) begin
                k++;
                if (k < 3) bus0.instr = q[k];
                else bus0.instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_accepts", k, 3);
        peek(3'd3);
        check("b2b_r3", bus0.dbg_data, 8'h5A);
        @(negedge clk);
        bus0.instr       = op(3'd0, 3'd3, 3'd1, 3'd2);
        bus0.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus0.instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_ready", bus0.instr_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_done", bus0.done, 0);
            check("abort_ready", bus0.instr_ready, 1);
        end
        peek(3'd3);
        check("abort_r3", bus0.dbg_data, 8'h00);
        check("abort_flags", {bus0.flag_c, bus0.flag_z}, 0);
        @(negedge clk);
        bus0.instr       = li(3'd1, 8'h77);
        bus0.instr_valid = 1'b1;
        rst              = 1'b1;
        @(posedge clk);
        #1;
        bus0.instr_valid = 1'b0;
        rst              = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prio_done", bus0.done, 0);
        end
        peek(3'd1);
        check("prio_r1", bus0.dbg_data, 8'h00);
        check("prio_r1_u1", bus1.dbg_data, 8'h5A);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
